// File: rtl/inv_stim_checker_pkg.sv
// Shared definitions for the inverter stimulus/check stage: FSM states,
// LFSR taps, default counter width and the LFSR step function.
package inv_test_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int LFSR_W_DEF = 8;

  // Taps for x^8+x^6+x^5+x^4+1 in a shift-left LFSR: feedback from bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // One LFSR step: shift left, new bit0 is the XOR of the tapped bits.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/inv_stim_checker_if.sv
// Control/status bus of the inverter stimulus/check stage. The master side
// launches runs; the slave side (the checker) reports progress and results.
interface inv_stim_checker_if
  import inv_test_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int LFSR_W = LFSR_W_DEF
);

  logic              start;
  logic [CNT_W-1:0]  num_vec;
  logic [LFSR_W-1:0] seed;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  vec_cnt;
  logic [CNT_W-1:0]  err_cnt;

  modport master (
    output start, num_vec, seed,
    input  busy, done, vec_cnt, err_cnt
  );

  modport slave (
    input  start, num_vec, seed,
    output busy, done, vec_cnt, err_cnt
  );

endinterface

// File: rtl/inv_stim_checker_sync2.sv
// Two-flop synchronizer for the inverter output pin, which is asynchronous
// to the check timing. Both stages clear to 0 on reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic q_r;

  // Shift the raw input through two flops to resolve metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      q_r    <= 1'b0;
    end else begin
      meta_r <= d;
      q_r    <= meta_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/inv_stim_checker.sv
// Stimulus and check stage around an inverter cell under test. Drives the
// cell input from an 8-bit LFSR, holds each vector SETTLE cycles, then checks
// the synchronized cell output for inversion and counts vectors/mismatches.
// SETTLE must be at least 3 (two sync flops plus one cycle of cell delay);
// only LFSR_W = 8 is supported by the fixed polynomial.
module inv_stim_checker
  import inv_test_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int SETTLE = 4,
  parameter int LFSR_W = LFSR_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  inv_stim_checker_if.slave   bus,
  output logic                in,
  input  logic                out
);

  localparam int                WAIT_W    = $clog2(SETTLE);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SETTLE - 1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [LFSR_W-1:0] LFSR_ZERO = {LFSR_W{1'b0}};
  localparam logic [LFSR_W-1:0] LFSR_ONE  = {{(LFSR_W-1){1'b0}}, 1'b1};

  state_t              state_r;
  logic [LFSR_W-1:0]   lfsr_r;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [CNT_W-1:0]    num_vec_r;
  logic [CNT_W-1:0]    vec_cnt_r;
  logic [CNT_W-1:0]    err_cnt_r;
  logic                in_r;
  logic                busy_r;
  logic                done_r;

  logic                out_s;
  logic [LFSR_W-1:0]   seed_eff_s;
  logic [LFSR_W-1:0]   lfsr_adv_s;
  logic [CNT_W-1:0]    vec_nxt_s;
  logic                mismatch_s;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d   (out),
    .q   (out_s)
  );

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  always_comb begin
    seed_eff_s = bus.seed;
    if (bus.seed == LFSR_ZERO) begin
      seed_eff_s = LFSR_ONE;
    end else begin
      seed_eff_s = bus.seed;
    end
  end

  // Next-vector LFSR state, vector count after this check, and the inversion check.
  always_comb begin
    lfsr_adv_s = lfsr_next(lfsr_r);
    vec_nxt_s  = vec_cnt_r + CNT_ONE;
    mismatch_s = (out_s == in_r);
  end

  // Run sequencer: launch, settle, check each vector, pulse done once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      lfsr_r     <= LFSR_ONE;
      wait_cnt_r <= WAIT_ZERO;
      num_vec_r  <= CNT_ZERO;
      vec_cnt_r  <= CNT_ZERO;
      err_cnt_r  <= CNT_ZERO;
      in_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            lfsr_r    <= seed_eff_s;
            num_vec_r <= bus.num_vec;
            vec_cnt_r <= CNT_ZERO;
            err_cnt_r <= CNT_ZERO;
            busy_r    <= 1'b1;
            if (bus.num_vec == CNT_ZERO) begin
              done_r  <= 1'b1;
              state_r <= DONE;
            end else begin
              in_r       <= seed_eff_s[0];
              wait_cnt_r <= WAIT_ZERO;
              state_r    <= WAIT;
            end
          end
        end
        WAIT: begin
          wait_cnt_r <= wait_cnt_r + WAIT_ONE;
          if (wait_cnt_r == WAIT_LAST) begin
            state_r <= CHECK;
          end
        end
        CHECK: begin
          vec_cnt_r <= vec_nxt_s;
          if (mismatch_s && (err_cnt_r != CNT_MAX)) begin
            err_cnt_r <= err_cnt_r + CNT_ONE;
          end
          if (vec_nxt_s == num_vec_r) begin
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            lfsr_r     <= lfsr_adv_s;
            in_r       <= lfsr_adv_s[0];
            wait_cnt_r <= WAIT_ZERO;
            state_r    <= WAIT;
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign in          = in_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.vec_cnt = vec_cnt_r;
  assign bus.err_cnt = err_cnt_r;

endmodule
